// File: rtl/scope_lane_buf.sv
// One-entry lane buffer: captures a word on load, releases it on take.
// clear empties the slot and wins over load.
module scope_lane_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/scope_lane_scan.sv
// Multi-lane collector: one-entry buffer per lane, round-robin arbiter and a
// single output register with valid/ready handshake and an emitted-word counter.
module scope_lane_scan #(
  parameter int NLANES = 5,
  parameter int WIDTH  = 8,
  parameter int CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [NLANES-1:0]       in_valid,
  input  logic [NLANES*WIDTH-1:0] in_data,
  output logic [NLANES-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [2:0]              out_lane,
  output logic [CNTW-1:0]         emit_cnt
);

  localparam int LANEW = 3;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [LANEW-1:0]   out_lane_q, out_lane_d;
  logic [LANEW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]    emit_cnt_q, emit_cnt_d;

  logic [NLANES-1:0]  full;
  logic [WIDTH-1:0]   buf_data [NLANES];
  logic               grant_found;
  logic [LANEW-1:0]   grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               can_load;
  logic               grant_en;
  int                 idx;

  for (genvar i = 0; i < NLANES; i++) begin : GEN_LANE
    logic lane_load;
    logic lane_take;
    assign lane_load = in_valid[i] & ~full[i];
    assign lane_take = grant_en && (grant_idx == LANEW'(i));
    scope_lane_buf #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .load      (lane_load),
      .load_data (in_data[i*WIDTH +: WIDTH]),
      .take      (lane_take),
      .full      (full[i]),
      .data      (buf_data[i])
    );
  end

  // First full lane at or after ptr, wrapping past the last lane.
  always_comb begin : SCAN
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    idx         = 0;
    for (int k = 0; k < NLANES; k++) begin
      idx = (int'(ptr_q) + k) % NLANES;
      if (!grant_found && full[idx]) begin
        grant_found = 1'b1;
        grant_idx   = LANEW'(idx);
        grant_data  = buf_data[idx];
      end
    end
  end

  assign can_load = (state_q == EMPTY) || out_ready;
  assign grant_en = can_load && grant_found && !clear;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    ptr_d      = ptr_q;
    emit_cnt_d = emit_cnt_q;
    if (state_q == HOLD && out_ready) begin
      emit_cnt_d = emit_cnt_q + CNTW'(1);
    end
    if (clear) begin
      state_d = EMPTY;
      ptr_d   = '0;
    end else if (grant_en) begin
      state_d    = HOLD;
      out_data_d = grant_data;
      out_lane_d = grant_idx;
      ptr_d      = (grant_idx == LANEW'(NLANES - 1)) ? '0 : grant_idx + LANEW'(1);
    end else if (can_load) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_lane_q <= '0;
      ptr_q      <= '0;
      emit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
      ptr_q      <= ptr_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign emit_cnt  = emit_cnt_q;

endmodule

// File: doc/scope_lane_scan.md
SCOPE_LANE_SCAN -- requirements
Module: scope_lane_scan

Interface
REQ-001 The block SHALL have parameter NLANES, default 5, giving the number of input lanes (legal range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width per lane.
REQ-003 The block SHALL have parameter CNTW, default 16, giving the width of the emitted-word counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port clear, input, 1 bit: synchronous flush of all lane buffers and the output register.
REQ-008 Port in_valid, input, NLANES bits: per-lane data-valid signal.
REQ-009 Port in_data, input, NLANES*WIDTH bits: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port in_ready, output, NLANES bits: per-lane buffer-empty indication.
REQ-011 Port out_valid, output, 1 bit: the output register holds a word.
REQ-012 Port out_ready, input, 1 bit: the downstream stage accepts the word.
REQ-013 Port out_data, output, WIDTH bits: the emitted word.
REQ-014 Port out_lane, output, 3 bits: index of the lane that produced out_data.
REQ-015 Port emit_cnt, output, CNTW bits: count of completed output handshakes.

Function
REQ-016 Each lane SHALL have a one-entry buffer, built in a generate loop whose block is named GEN_LANE, so that each buffer is reachable as GEN_LANE[i].
REQ-017 in_ready[i] SHALL equal the inverse of lane i's full flag (registered; it does not depend combinationally on out_ready).
REQ-018 Lane accept SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge; the buffer then captures the data and sets its full flag.
REQ-019 Output register states SHALL be EMPTY and HOLD.
REQ-020 The output register SHALL load when in EMPTY, or when in HOLD with out_ready high, provided at least one lane is full.
REQ-021 Lane selection SHALL be round-robin:
  - scan begins at pointer ptr, increasing with wrap NLANES-1 -> 0;
  - the first full lane found is granted;
  - the scan is a for loop over an integer inside a named always block SCAN.
REQ-022 On a grant, the following SHALL happen at the same edge:
  - the granted lane's full flag clears;
  - out_data and out_lane load;
  - ptr becomes grant+1 modulo NLANES.
REQ-023 Latency SHALL be 2 cycles: a lane accept at edge E gives out_valid high after edge E+1, provided the output register is free and no other lane wins.
REQ-024 In HOLD with out_ready low, out_data, out_lane and all lane buffers SHALL stay stable.
REQ-025 In HOLD with out_ready high and no lane full, the state SHALL go to EMPTY and out_valid SHALL drop.
REQ-026 Throughput SHALL be one word per cycle while lanes are full and out_ready is high.
REQ-027 emit_cnt SHALL increment on each out_valid&&out_ready edge and wrap modulo 2^CNTW; clear does not affect it.
REQ-028 clear SHALL take priority over lane accepts and grants in the same cycle:
  - all full flags clear;
  - the state becomes EMPTY;
  - ptr becomes 0.
REQ-029 A lane whose full flag clears at edge E SHALL show in_ready high after E; it may accept at edge E+1 at the earliest.

Reset
REQ-030 While rst_n is low, the block SHALL hold all full flags at 0.
REQ-031 While rst_n is low, in_ready SHALL be all ones.
REQ-032 While rst_n is low, out_valid SHALL be 0 and the state SHALL be EMPTY.
REQ-033 While rst_n is low, out_data and out_lane SHALL be 0.
REQ-034 While rst_n is low, ptr and emit_cnt SHALL be 0.
REQ-035 Reset asserted mid-transfer SHALL discard buffered and held words; no word is emitted after reset releases until a new lane accept.

Structure
REQ-036 No shared package SHALL be used; the lane index width SHALL be a localparam, fixed at 3 bits.
REQ-037 The lane buffer SHALL be one sub-module, scope_lane_buf, instantiated inside GEN_LANE as instance u_buf.
REQ-038 The sub-module SHALL provide full, data, load, take and clear.
REQ-039 The arbiter and output register SHALL be inline in the top module.

Verification
REQ-040 Single word: lane 2 accepts 8'hA5 with out_ready=1 -> out_valid high 2 cycles later, out_data=A5, out_lane=2, emit_cnt=1.
REQ-041 All lanes full, ptr=0, out_ready=1 -> out_lane sequence 0,1,2,3,4 on consecutive cycles; emit_cnt=5; in_ready returns to 5'b11111.
REQ-042 Backpressure: out_ready=0 for 4 cycles with lanes 1 and 3 full -> out_lane stays 1 and out_data stays stable; when out_ready rises, lane 3 is next.
REQ-043 Wrap: ptr=4 with lanes 0 and 4 full -> grant 4 then 0.
REQ-044 clear in the same cycle as an accept on lane 0 and a grant -> all lanes empty, out_valid=0, ptr=0, emit_cnt unchanged.
REQ-045 Counter wrap at CNTW=4: 16 handshakes -> emit_cnt=0; rst_n pulsed low mid-HOLD -> out_valid drops immediately and all outputs take their REQ-030 to REQ-034 values.
